// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state encoding and PC-select codes shared by the interrupt
// sequencer and the fetch controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DRAIN,
        S_PUSH_HI,
        S_PUSH_LO,
        S_PUSH_F,
        S_VECTOR,
        S_POP_F,
        S_POP_LO,
        S_POP_HI,
        S_RESTORE
    } state_t;

    // PCSEL_INT must match the fetch controller's interrupt source code.
    localparam logic [1:0] PCSEL_NONE = 2'b00;
    localparam logic [1:0] PCSEL_INT  = 2'b01;
    localparam logic [1:0] PCSEL_RET  = 2'b10;

endpackage

// File: rtl/int_control_if.sv
// int_control_if: stack access bus between the sequencer and the memory stage.
// master: push/pop request + write data out; ack + read data in.
interface int_control_if #(
    parameter int DATA_W = 16
);

    logic              stackPush;
    logic              stackPop;
    logic [DATA_W-1:0] stackData;
    logic              stackAck;
    logic [DATA_W-1:0] stackDataIn;

    modport master (
        output stackPush,
        output stackPop,
        output stackData,
        input  stackAck,
        input  stackDataIn
    );

    modport slave (
        input  stackPush,
        input  stackPop,
        input  stackData,
        output stackAck,
        output stackDataIn
    );

endinterface

// File: rtl/drain_counter.sv
// drain_counter: loadable down-counter with a zero flag.
// Ports: clk, rst (async active-low), load/loadVal, dec, zero.
module drain_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/int_control.sv
// int_control: interrupt entry/exit sequencer (drain, push frame, vector; pop, restore).
// Ports: clk, rst, intReq, rti, pcIn, flagsIn, stack bus, stall/flush, pcLoad/pcSel/pcOut, flagsLoad/flagsOut, inService.
module int_control
    import ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int FLAG_W       = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              intReq,
    input  logic              rti,
    input  logic [ADDR_W-1:0] pcIn,
    input  logic [FLAG_W-1:0] flagsIn,
    int_control_if.master     bus,
    output logic              stall,
    output logic              flush,
    output logic              pcLoad,
    output logic [1:0]        pcSel,
    output logic [ADDR_W-1:0] pcOut,
    output logic              flagsLoad,
    output logic [FLAG_W-1:0] flagsOut,
    output logic              inService
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;
    localparam int HI_W  = ADDR_W - DATA_W;

    state_t            state;
    logic              pending;
    logic [HI_W-1:0]   frameHi;
    logic [DATA_W-1:0] frameLo;
    logic [FLAG_W-1:0] frameFlags;
    logic              takeInt;
    logic              cntZero;

    assign takeInt = (intReq || pending) && !inService;

    drain_counter #(
        .W(CNT_W)
    ) u_drain (
        .clk    (clk),
        .rst    (rst),
        .load   (state == S_IDLE && takeInt),
        .loadVal(CNT_W'(DRAIN_CYCLES - 1)),
        .dec    (state == S_DRAIN),
        .zero   (cntZero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pending    <= 1'b0;
            inService  <= 1'b0;
            frameHi    <= '0;
            frameLo    <= '0;
            frameFlags <= '0;
        end else begin
            // A request arriving on the VECTOR edge survives into the handler.
            if (intReq) begin
                pending <= 1'b1;
            end else if (state == S_VECTOR) begin
                pending <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (takeInt) begin
                        state      <= S_DRAIN;
                        frameHi    <= pcIn[ADDR_W-1:DATA_W];
                        frameLo    <= pcIn[DATA_W-1:0];
                        frameFlags <= flagsIn;
                    end else if (rti && inService) begin
                        state <= S_POP_F;
                    end
                end
                S_DRAIN: begin
                    if (cntZero) state <= S_PUSH_HI;
                end
                S_PUSH_HI: begin
                    if (bus.stackAck) state <= S_PUSH_LO;
                end
                S_PUSH_LO: begin
                    if (bus.stackAck) state <= S_PUSH_F;
                end
                S_PUSH_F: begin
                    if (bus.stackAck) state <= S_VECTOR;
                end
                S_VECTOR: begin
                    inService <= 1'b1;
                    state     <= S_IDLE;
                end
                S_POP_F: begin
                    if (bus.stackAck) begin
                        frameFlags <= bus.stackDataIn[FLAG_W-1:0];
                        state      <= S_POP_LO;
                    end
                end
                S_POP_LO: begin
                    if (bus.stackAck) begin
                        frameLo <= bus.stackDataIn;
                        state   <= S_POP_HI;
                    end
                end
                S_POP_HI: begin
                    if (bus.stackAck) begin
                        frameHi <= bus.stackDataIn[HI_W-1:0];
                        state   <= S_RESTORE;
                    end
                end
                S_RESTORE: begin
                    inService <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall         = (state != S_IDLE);
        flush         = 1'b0;
        bus.stackPush = 1'b0;
        bus.stackPop  = 1'b0;
        bus.stackData = '0;
        pcLoad        = 1'b0;
        pcSel         = PCSEL_NONE;
        pcOut         = '0;
        flagsLoad     = 1'b0;
        flagsOut      = '0;
        unique case (state)
            S_DRAIN: flush = 1'b1;
            S_PUSH_HI: begin
                bus.stackPush = 1'b1;
                bus.stackData = DATA_W'(frameHi);
            end
            S_PUSH_LO: begin
                bus.stackPush = 1'b1;
                bus.stackData = frameLo;
            end
            S_PUSH_F: begin
                bus.stackPush = 1'b1;
                bus.stackData = DATA_W'(frameFlags);
            end
            S_VECTOR: begin
                flush  = 1'b1;
                pcLoad = 1'b1;
                pcSel  = PCSEL_INT;
            end
            S_POP_F, S_POP_LO, S_POP_HI: bus.stackPop = 1'b1;
            S_RESTORE: begin
                flush     = 1'b1;
                pcLoad    = 1'b1;
                pcSel     = PCSEL_RET;
                pcOut     = {frameHi, frameLo};
                flagsLoad = 1'b1;
                flagsOut  = frameFlags;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_control.sv
// tb_int_control: directed scenarios for the interrupt sequencer.
// Snapshot = {stall,flush,push,pop,pcLoad,pcSel,flagsLoad,inService,stackData}.
module tb_int_control;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        intReq = 1'b0;
    logic        rti = 1'b0;
    logic [31:0] pcIn = '0;
    logic [3:0]  flagsIn = '0;
    logic        stall, flush, pcLoad, flagsLoad, inService;
    logic [1:0]  pcSel;
    logic [31:0] pcOut;
    logic [3:0]  flagsOut;
    int          checks = 0;
    int          fails = 0;

    int_control_if #(.DATA_W(16)) bus ();

    int_control #(
        .ADDR_W(32), .DATA_W(16), .FLAG_W(4), .DRAIN_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .intReq(intReq), .rti(rti),
        .pcIn(pcIn), .flagsIn(flagsIn), .bus(bus.master),
        .stall(stall), .flush(flush), .pcLoad(pcLoad), .pcSel(pcSel),
        .pcOut(pcOut), .flagsLoad(flagsLoad), .flagsOut(flagsOut),
        .inService(inService)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] snap();
        return {stall, flush, bus.stackPush, bus.stackPop, pcLoad,
                pcSel, flagsLoad, inService, bus.stackData};
    endfunction

    function automatic logic [24:0] e(input logic st, fl, pu, po, pl,
                                      input logic [1:0] ps,
                                      input logic fld, ins,
                                      input logic [15:0] d);
        return {st, fl, pu, po, pl, ps, fld, ins, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.stackAck = 1'b1;
        bus.stackDataIn = '0;
        tick();
        tick();
        checks++;
        if (snap() !== 25'h0 || pcOut !== 32'h0 || flagsOut !== 4'h0) begin
            fails++;
            $display("FAIL reset snap=%h pc=%h fl=%h exp 0", snap(), pcOut, flagsOut);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (snap() !== 25'h0) begin
            fails++;
            $display("FAIL reset_idle snap=%h exp 0", snap());
        end
    endtask

    // pulse=0: entry comes from an already pending request.
    task automatic test_entry(input logic [31:0] pc, input logic [3:0] fl,
                              input logic pulse, input string tag);
        logic [24:0] exp [7];
        exp[0] = e(1, 1, 0, 0, 0, 2'b00, 0, 0, 16'h0);
        exp[1] = e(1, 1, 0, 0, 0, 2'b00, 0, 0, 16'h0);
        exp[2] = e(1, 0, 1, 0, 0, 2'b00, 0, 0, pc[31:16]);
        exp[3] = e(1, 0, 1, 0, 0, 2'b00, 0, 0, pc[15:0]);
        exp[4] = e(1, 0, 1, 0, 0, 2'b00, 0, 0, {12'h0, fl});
        exp[5] = e(1, 1, 0, 0, 1, 2'b01, 0, 0, 16'h0);
        exp[6] = e(0, 0, 0, 0, 0, 2'b00, 0, 1, 16'h0);
        bus.stackAck = 1'b1;
        pcIn = pc;
        flagsIn = fl;
        intReq = pulse;
        tick();
        intReq = 1'b0;
        pcIn = 32'hFFFF_FFFF;
        flagsIn = 4'hF;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (snap() !== exp[i]) begin
                fails++;
                $display("FAIL %s_c%0d snap=%h exp %h", tag, i, snap(), exp[i]);
            end
            if (i < 6) tick();
        end
    endtask

    task automatic test_exit(input logic [15:0] dF, dLo, dHi,
                             input logic [31:0] pc, input logic [3:0] fl,
                             input string tag);
        logic [15:0] dat [3];
        dat[0] = dF;
        dat[1] = dLo;
        dat[2] = dHi;
        bus.stackAck = 1'b1;
        rti = 1'b1;
        tick();
        rti = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (snap() !== e(1, 0, 0, 1, 0, 2'b00, 0, 1, 16'h0)) begin
                fails++;
                $display("FAIL %s_pop%0d snap=%h", tag, i, snap());
            end
            bus.stackDataIn = dat[i];
            tick();
        end
        bus.stackDataIn = '0;
        checks++;
        if (snap() !== e(1, 1, 0, 0, 1, 2'b10, 1, 1, 16'h0)
            || pcOut !== pc || flagsOut !== fl) begin
            fails++;
            $display("FAIL %s_restore snap=%h pc=%h fl=%h exp pc %h fl %h",
                     tag, snap(), pcOut, flagsOut, pc, fl);
        end
        tick();
        checks++;
        if (snap() !== 25'h0) begin
            fails++;
            $display("FAIL %s_idle snap=%h exp 0", tag, snap());
        end
    endtask

    task automatic test_backpressure();
        bus.stackAck = 1'b1;
        pcIn = 32'h0001_2345;
        flagsIn = 4'hA;
        intReq = 1'b1;
        tick();
        intReq = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (snap() !== e(1, 0, 1, 0, 0, 2'b00, 0, 0, 16'h2345)) begin
            fails++;
            $display("FAIL bp_push_lo snap=%h", snap());
        end
        bus.stackAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (snap() !== e(1, 0, 1, 0, 0, 2'b00, 0, 0, 16'h2345)) begin
                fails++;
                $display("FAIL bp_hold%0d snap=%h exp data 2345", i, snap());
            end
        end
        bus.stackAck = 1'b1;
        tick();
        checks++;
        if (snap() !== e(1, 0, 1, 0, 0, 2'b00, 0, 0, 16'h000A)) begin
            fails++;
            $display("FAIL bp_push_f snap=%h", snap());
        end
        tick();
        tick();
        checks++;
        if (inService !== 1'b1 || stall !== 1'b0) begin
            fails++;
            $display("FAIL bp_done ins=%b stall=%b exp 1 0", inService, stall);
        end
    endtask

    task automatic test_nested();
        intReq = 1'b1;
        tick();
        intReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (snap() !== e(0, 0, 0, 0, 0, 2'b00, 0, 1, 16'h0)) begin
                fails++;
                $display("FAIL nest_blocked%0d snap=%h", i, snap());
            end
            tick();
        end
        test_exit(16'hFFF3, 16'h0055, 16'hBEEF, 32'hBEEF_0055, 4'h3, "nest_exit");
        test_entry(32'h0BAD_F00D, 4'h5, 1'b0, "nest_entry");
        test_exit(16'h0005, 16'hF00D, 16'h0BAD, 32'h0BAD_F00D, 4'h5, "nest_exit2");
        rti = 1'b1;
        tick();
        rti = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (snap() !== 25'h0) begin
                fails++;
                $display("FAIL rti_idle%0d snap=%h exp 0", i, snap());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        test_entry(32'h00C0_FFEE, 4'h6, 1'b1, "rm_entry");
        bus.stackAck = 1'b1;
        rti = 1'b1;
        tick();
        rti = 1'b0;
        bus.stackDataIn = 16'h0006;
        tick();
        checks++;
        if (bus.stackPop !== 1'b1) begin
            fails++;
            $display("FAIL rm_pop_lo pop=%b exp 1", bus.stackPop);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (snap() !== 25'h0 || pcOut !== 32'h0 || flagsOut !== 4'h0) begin
            fails++;
            $display("FAIL rm_async snap=%h pc=%h fl=%h exp 0", snap(), pcOut, flagsOut);
        end
        tick();
        rst = 1'b1;
        bus.stackDataIn = '0;
        tick();
        test_entry(32'h0001_2345, 4'hA, 1'b1, "rm_reentry");
    endtask

    initial begin
        test_reset();
        test_entry(32'h0001_2345, 4'hA, 1'b1, "entry");
        test_exit(16'h000A, 16'h2345, 16'h0001, 32'h0001_2345, 4'hA, "exit");
        test_backpressure();
        test_nested();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
